// File: rtl/encoder_pkg.sv
// Shared types and default sizing for the serial encoder scheduler.
// The PARITY state exists only when ENCODER_PARITY_EN is defined.
package encoder_pkg;

   localparam int NUM_REQ_DEFAULT = 4;
   localparam int MSG_W_DEFAULT   = 8;

`ifdef ENCODER_PARITY_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      GAP    = 2'd2,
      PARITY = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;
`endif

endpackage

// File: rtl/encoder_scheduler_piso.sv
// Parallel-in serial-out shifter, LSB first, with a bit counter.
// done flags the cycle presenting the last message bit.
module piso_shifter
   import encoder_pkg::*;
#(
   parameter int MSG_W = MSG_W_DEFAULT
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic             shift_en,
   input  logic [MSG_W-1:0] data_in,
   output logic             bit_out,
   output logic             done
);

   localparam int CNT_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;

   logic [MSG_W-1:0] shift_reg;
   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shift_reg <= '0;
         count_reg <= '0;
      end else if (load) begin
         shift_reg <= data_in;
         count_reg <= '0;
      end else if (shift_en) begin
         shift_reg <= shift_reg >> 1;
         count_reg <= done ? '0 : count_reg + 1'b1;
      end
   end

   assign bit_out = shift_reg[0];
   assign done    = (count_reg == CNT_W'(MSG_W - 1));

endmodule

// File: rtl/encoder_scheduler.sv
// Round-robin arbiter feeding one serial encoder line: IDLE -> SHIFT -> [PARITY] -> GAP.
// Define ENCODER_PARITY_EN to append an even-parity bit to every frame.
module encoder_scheduler
   import encoder_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEFAULT,
   parameter int MSG_W   = MSG_W_DEFAULT
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*MSG_W-1:0]   msg_in,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       serial_out,
   output logic                       frame_valid,
   output logic                       frame_start,
   output logic [$clog2(NUM_REQ)-1:0] src_id,
   output logic                       busy
);

   localparam int ID_W = $clog2(NUM_REQ);

   state_t            state_reg, state_next;
   logic [ID_W-1:0]   rr_ptr_reg, src_id_reg, winner;
   logic [NUM_REQ-1:0] grant_reg;
   logic              frame_start_reg;
   logic              load, shift_en, shift_done, shift_bit;
   logic [MSG_W-1:0]  msg_arr [NUM_REQ];
   logic [MSG_W-1:0]  winner_msg;
   int                arb_dist, arb_best;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign msg_arr[gi] = msg_in[gi*MSG_W +: MSG_W];
      end
   endgenerate

   assign winner_msg = msg_arr[winner];

   // Winner is the requester with the smallest circular distance from rr_ptr.
   always_comb begin
      winner   = '0;
      arb_best = NUM_REQ;
      arb_dist = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         arb_dist = i - int'(rr_ptr_reg);
         if (arb_dist < 0) arb_dist = arb_dist + NUM_REQ;
         if (req[i] && (arb_dist < arb_best)) begin
            arb_best = arb_dist;
            winner   = ID_W'(i);
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      shift_en   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (|req) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (shift_done) begin
`ifdef ENCODER_PARITY_EN
               state_next = PARITY;
`else
               state_next = GAP;
`endif
            end
         end
`ifdef ENCODER_PARITY_EN
         PARITY: state_next = GAP;
`endif
         GAP:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_reg      <= '0;
         src_id_reg      <= '0;
         grant_reg       <= '0;
         frame_start_reg <= 1'b0;
      end else begin
         grant_reg       <= load ? (NUM_REQ'(1) << winner) : '0;
         frame_start_reg <= load;
         if (load) begin
            src_id_reg <= winner;
            rr_ptr_reg <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
         end
      end
   end

`ifdef ENCODER_PARITY_EN
   logic parity_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)  parity_reg <= 1'b0;
      else if (load) parity_reg <= ^winner_msg;
   end
`endif

   piso_shifter #(.MSG_W(MSG_W)) u_piso (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (load),
      .shift_en (shift_en),
      .data_in  (winner_msg),
      .bit_out  (shift_bit),
      .done     (shift_done)
   );

   // serial_out is forced low whenever no frame bit is on the line.
   always_comb begin
      frame_valid = 1'b0;
      serial_out  = 1'b0;
      case (state_reg)
         SHIFT: begin
            frame_valid = 1'b1;
            serial_out  = shift_bit;
         end
`ifdef ENCODER_PARITY_EN
         PARITY: begin
            frame_valid = 1'b1;
            serial_out  = parity_reg;
         end
`endif
         default: ;
      endcase
   end

   assign busy        = (state_reg != IDLE);
   assign grant       = grant_reg;
   assign frame_start = frame_start_reg;
   assign src_id      = busy ? src_id_reg : '0;

endmodule
